// File: rtl/mdio_poll_sched_pkg.sv
// Shared definitions for the MDIO poll scheduler.
// Holds the FSM state encoding, the resolved speed codes, the BMSR register
// number and link bit, and the bit positions inside the PHY-specific speed
// status register. It also holds the helper that maps the raw speed field
// onto a speed code.
package mdio_poll_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_POLL_BMSR_REQ  = 3'd1,
        ST_POLL_BMSR_WAIT = 3'd2,
        ST_POLL_SPD_REQ   = 3'd3,
        ST_POLL_SPD_WAIT  = 3'd4,
        ST_HOST_REQ       = 3'd5,
        ST_HOST_WAIT      = 3'd6,
        ST_HOST_DONE      = 3'd7
    } state_e;

    localparam logic [1:0] SPD_10M   = 2'b00;
    localparam logic [1:0] SPD_100M  = 2'b01;
    localparam logic [1:0] SPD_1000M = 2'b10;

    localparam logic [4:0] BMSR_REG      = 5'd1;
    localparam int         BMSR_LINK_BIT = 2;

    // Field positions inside the PHY-specific speed status register
    localparam int SPD_FIELD_HI     = 15;
    localparam int SPD_FIELD_LO     = 14;
    localparam int SPD_DUPLEX_BIT   = 13;
    localparam int SPD_RESOLVED_BIT = 11;

    // The reserved field value 11 is treated as 10M
    function automatic logic [1:0] map_speed(input logic [1:0] code);
        return (code == 2'b11) ? SPD_10M : code;
    endfunction

endpackage

// File: rtl/mdio_poll_timer.sv
// Free-running poll period timer.
// The counter runs from 0 to POLL_CYCLES-1 and then wraps. o_wrap is high for
// the single cycle in which the count sits at POLL_CYCLES-1.
// Ports:
//   i_clk  - clock
//   i_rst  - synchronous active-high reset (count returns to 0)
//   o_wrap - one-cycle pulse on the last count of each period
module mdio_poll_timer #(
    parameter int POLL_CYCLES = 1250000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_wrap
);

    localparam int             CW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(POLL_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        o_wrap  = (count_q == LAST);
        count_d = o_wrap ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mdio_poll_sched.sv
// MDIO access scheduler.
// The block shares one PHY register access port between host register
// accesses and a periodic link poll. The poll reads BMSR. If the link bit is
// set, it then reads the PHY-specific speed register. From these reads it
// resolves the link, speed and duplex.
// Ports:
//   i_clk, i_rst                       - clock, synchronous active-high reset
//   i_host_request/rdwn/reg/wr_data    - host access request (level, held to done)
//   o_host_rd_data, o_host_done        - host read data and one-cycle completion pulse
//   o_phy_request/rdwn/reg/wr_data     - one-cycle request and stable access fields
//   i_phy_done, i_phy_rd_data          - PHY access completion and read data
//   o_link_up, o_speed, o_full_duplex  - resolved link status
//   o_status_chg                       - one-cycle pulse when the resolved status changes
module mdio_poll_sched
    import mdio_poll_sched_pkg::*;
#(
    parameter int         POLL_CYCLES = 1250000,
    parameter logic [4:0] PHY_SPD_REG = 5'd17
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_host_request,
    input  logic        i_host_rdwn,
    input  logic [4:0]  i_host_reg,
    input  logic [15:0] i_host_wr_data,
    output logic [15:0] o_host_rd_data,
    output logic        o_host_done,
    output logic        o_phy_request,
    output logic        o_phy_rdwn,
    output logic [4:0]  o_phy_reg,
    output logic [31:0] o_phy_wr_data,
    input  logic        i_phy_done,
    input  logic [31:0] i_phy_rd_data,
    output logic        o_link_up,
    output logic [1:0]  o_speed,
    output logic        o_full_duplex,
    output logic        o_status_chg
);

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic        last_host_q, last_host_d;   // 1: host was served last
    logic        phy_rdwn_q, phy_rdwn_d;
    logic [4:0]  phy_reg_q, phy_reg_d;
    logic [15:0] phy_wr_q, phy_wr_d;
    logic [15:0] host_rd_q, host_rd_d;
    logic        link_q, link_d;
    logic [1:0]  speed_q, speed_d;
    logic        duplex_q, duplex_d;
    logic        chg_q, chg_d;

    logic        poll_wrap;
    logic        resolve;
    logic        res_link;
    logic [1:0]  res_speed;
    logic        res_duplex;
    logic        unused_rd_hi;

    assign unused_rd_hi = ^i_phy_rd_data[31:16];

    mdio_poll_timer #(
        .POLL_CYCLES (POLL_CYCLES)
    ) u_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_wrap (poll_wrap)
    );

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        last_host_d = last_host_q;
        phy_rdwn_d  = phy_rdwn_q;
        phy_reg_d   = phy_reg_q;
        phy_wr_d    = phy_wr_q;
        host_rd_d   = host_rd_q;
        link_d      = link_q;
        speed_d     = speed_q;
        duplex_d    = duplex_q;
        chg_d       = 1'b0;
        resolve     = 1'b0;
        res_link    = 1'b0;
        res_speed   = SPD_10M;
        res_duplex  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The host wins when it is alone, or on a tie when the poll went last
                if (i_host_request && (!pending_q || !last_host_q)) begin
                    state_d     = ST_HOST_REQ;
                    last_host_d = 1'b1;
                    phy_rdwn_d  = i_host_rdwn;
                    phy_reg_d   = i_host_reg;
                    phy_wr_d    = i_host_wr_data;
                end else if (pending_q) begin
                    state_d     = ST_POLL_BMSR_REQ;
                    pending_d   = 1'b0;
                    last_host_d = 1'b0;
                    phy_rdwn_d  = 1'b1;
                    phy_reg_d   = BMSR_REG;
                    phy_wr_d    = '0;
                end
            end
            ST_POLL_BMSR_REQ: state_d = ST_POLL_BMSR_WAIT;
            ST_POLL_BMSR_WAIT: begin
                if (i_phy_done) begin
                    if (i_phy_rd_data[BMSR_LINK_BIT]) begin
                        state_d   = ST_POLL_SPD_REQ;
                        phy_reg_d = PHY_SPD_REG;
                    end else begin
                        state_d = ST_IDLE;
                        resolve = 1'b1;
                    end
                end
            end
            ST_POLL_SPD_REQ: state_d = ST_POLL_SPD_WAIT;
            ST_POLL_SPD_WAIT: begin
                if (i_phy_done) begin
                    state_d = ST_IDLE;
                    resolve = 1'b1;
                    if (i_phy_rd_data[SPD_RESOLVED_BIT]) begin
                        res_link   = 1'b1;
                        res_speed  = map_speed(i_phy_rd_data[SPD_FIELD_HI:SPD_FIELD_LO]);
                        res_duplex = i_phy_rd_data[SPD_DUPLEX_BIT];
                    end
                end
            end
            ST_HOST_REQ: state_d = ST_HOST_WAIT;
            ST_HOST_WAIT: begin
                if (i_phy_done) begin
                    state_d = ST_HOST_DONE;
                    if (phy_rdwn_q) begin
                        host_rd_d = i_phy_rd_data[15:0];
                    end
                end
            end
            ST_HOST_DONE: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        if (resolve) begin
            link_d   = res_link;
            speed_d  = res_speed;
            duplex_d = res_duplex;
            chg_d    = (res_link != link_q) || (res_speed != speed_q) ||
                       (res_duplex != duplex_q);
        end

        // An expiry beats a same-cycle grant clear; repeated expiries collapse
        if (poll_wrap) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= 1'b1;
            last_host_q <= 1'b1;
            phy_rdwn_q  <= 1'b0;
            phy_reg_q   <= '0;
            phy_wr_q    <= '0;
            host_rd_q   <= '0;
            link_q      <= 1'b0;
            speed_q     <= SPD_10M;
            duplex_q    <= 1'b0;
            chg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            last_host_q <= last_host_d;
            phy_rdwn_q  <= phy_rdwn_d;
            phy_reg_q   <= phy_reg_d;
            phy_wr_q    <= phy_wr_d;
            host_rd_q   <= host_rd_d;
            link_q      <= link_d;
            speed_q     <= speed_d;
            duplex_q    <= duplex_d;
            chg_q       <= chg_d;
        end
    end

    assign o_phy_request  = (state_q == ST_POLL_BMSR_REQ) || (state_q == ST_POLL_SPD_REQ) ||
                            (state_q == ST_HOST_REQ);
    assign o_phy_rdwn     = phy_rdwn_q;
    assign o_phy_reg      = phy_reg_q;
    assign o_phy_wr_data  = {16'h0000, phy_wr_q};
    assign o_host_done    = (state_q == ST_HOST_DONE);
    assign o_host_rd_data = host_rd_q;
    assign o_link_up      = link_q;
    assign o_speed        = speed_q;
    assign o_full_duplex  = duplex_q;
    assign o_status_chg   = chg_q;

endmodule

// File: tb/tb_mdio_poll_sched.sv
// Directed testbench for mdio_poll_sched with a 64-cycle poll period.
// A PHY model answers each request after phy_delay cycles and prints one line
// per transaction. The directed sequence walks through power-up polling, link
// loss, host/poll arbitration, a host write, a long PHY stall and a reset
// taken mid-access.
module tb_mdio_poll_sched;

    localparam int POLL = 64;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_host_request = 1'b0;
    logic        i_host_rdwn = 1'b0;
    logic [4:0]  i_host_reg = '0;
    logic [15:0] i_host_wr_data = '0;
    logic [15:0] o_host_rd_data;
    logic        o_host_done;
    logic        o_phy_request;
    logic        o_phy_rdwn;
    logic [4:0]  o_phy_reg;
    logic [31:0] o_phy_wr_data;
    logic        i_phy_done = 1'b0;
    logic [31:0] i_phy_rd_data = '0;
    logic        o_link_up;
    logic [1:0]  o_speed;
    logic        o_full_duplex;
    logic        o_status_chg;

    always #5 clk = ~clk;

    mdio_poll_sched #(
        .POLL_CYCLES (POLL),
        .PHY_SPD_REG (5'd17)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_host_request (i_host_request),
        .i_host_rdwn    (i_host_rdwn),
        .i_host_reg     (i_host_reg),
        .i_host_wr_data (i_host_wr_data),
        .o_host_rd_data (o_host_rd_data),
        .o_host_done    (o_host_done),
        .o_phy_request  (o_phy_request),
        .o_phy_rdwn     (o_phy_rdwn),
        .o_phy_reg      (o_phy_reg),
        .o_phy_wr_data  (o_phy_wr_data),
        .i_phy_done     (i_phy_done),
        .i_phy_rd_data  (i_phy_rd_data),
        .o_link_up      (o_link_up),
        .o_speed        (o_speed),
        .o_full_duplex  (o_full_duplex),
        .o_status_chg   (o_status_chg)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;          // clock edges since reset release
    int phy_delay = 3;
    int req_cnt = 0;
    int chg_cnt = 0;
    int done_cnt = 0;
    logic [4:0]  log_reg  [0:31];
    logic        log_rdwn [0:31];
    logic [15:0] phy_regs [0:31];
    logic        busy = 1'b0;
    int          busy_cnt = 0;
    logic [15:0] busy_data = '0;

    always @(posedge clk) begin
        cyc <= i_rst ? 0 : cyc + 1;
    end

    // PHY model and output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (i_rst) begin
            i_phy_done = 1'b0;
            busy       = 1'b0;
        end else begin
            i_phy_done = 1'b0;
            if (busy) begin
                if (busy_cnt == 0) begin
                    i_phy_done    = 1'b1;
                    i_phy_rd_data = {16'hA5A5, busy_data};
                    busy          = 1'b0;
                end else begin
                    busy_cnt = busy_cnt - 1;
                end
            end
            if (o_phy_request) begin
                if (req_cnt < 32) begin
                    log_reg[req_cnt]  = o_phy_reg;
                    log_rdwn[req_cnt] = o_phy_rdwn;
                end
                if (!o_phy_rdwn) begin
                    phy_regs[o_phy_reg] = o_phy_wr_data[15:0];
                end
                busy_data = phy_regs[o_phy_reg];
                busy      = 1'b1;
                busy_cnt  = phy_delay - 1;
                $display("phy txn %0d cyc=%0d reg=%0d rdwn=%0b wr=%h rd=%h",
                         req_cnt, cyc, o_phy_reg, o_phy_rdwn, o_phy_wr_data, busy_data);
                req_cnt = req_cnt + 1;
            end
            if (o_status_chg) chg_cnt = chg_cnt + 1;
            if (o_host_done)  done_cnt = done_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_phy_req(input string tag, input int max);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (o_phy_request) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_host_done(input string tag, input int max);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (o_host_done) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_link"},    {31'd0, o_link_up}, 32'd0);
        check({tag, "_speed"},   {30'd0, o_speed}, 32'd0);
        check({tag, "_duplex"},  {31'd0, o_full_duplex}, 32'd0);
        check({tag, "_chg"},     {31'd0, o_status_chg}, 32'd0);
        check({tag, "_hdone"},   {31'd0, o_host_done}, 32'd0);
        check({tag, "_hrd"},     {16'd0, o_host_rd_data}, 32'd0);
        check({tag, "_preq"},    {31'd0, o_phy_request}, 32'd0);
        check({tag, "_prdwn"},   {31'd0, o_phy_rdwn}, 32'd0);
        check({tag, "_preg"},    {27'd0, o_phy_reg}, 32'd0);
        check({tag, "_pwr"},     o_phy_wr_data, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) phy_regs[i] = 16'h0000;
        phy_regs[0]  = 16'h1234;
        phy_regs[1]  = 16'h796D;
        phy_regs[17] = 16'hAC00;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        i_rst = 1'b0;

        // The first poll is issued in the first cycle after release
        wait_cyc(1);
        check("first_req", {31'd0, o_phy_request}, 32'd1);
        check("first_reg", {27'd0, o_phy_reg}, 32'd1);
        check("first_rdwn", {31'd0, o_phy_rdwn}, 32'd1);

        // Scenario 1: link up, 1000M, full duplex
        wait_cyc(20);
        check("s1_reqs", req_cnt, 32'd2);
        check("s1_reg0", {27'd0, log_reg[0]}, 32'd1);
        check("s1_reg1", {27'd0, log_reg[1]}, 32'd17);
        check("s1_link", {31'd0, o_link_up}, 32'd1);
        check("s1_speed", {30'd0, o_speed}, 32'd2);
        check("s1_duplex", {31'd0, o_full_duplex}, 32'd1);
        check("s1_chg", chg_cnt, 32'd1);

        // Scenario 2: link down at the next period, no speed read
        phy_regs[1] = 16'h7969;
        wait_cyc(85);
        check("s2_reqs", req_cnt, 32'd3);
        check("s2_reg", {27'd0, log_reg[2]}, 32'd1);
        check("s2_link", {31'd0, o_link_up}, 32'd0);
        check("s2_speed", {30'd0, o_speed}, 32'd0);
        check("s2_duplex", {31'd0, o_full_duplex}, 32'd0);
        check("s2_chg", chg_cnt, 32'd2);

        // Scenario 3: host read in the cycle the poll becomes pending
        wait_cyc(2 * POLL);
        i_host_request = 1'b1;
        i_host_rdwn    = 1'b1;
        i_host_reg     = 5'd0;
        wait_host_done("s3_done_seen", 40);
        check("s3_rd_data", {16'd0, o_host_rd_data}, 32'h1234);
        check("s3_host_first_reg", {27'd0, log_reg[3]}, 32'd0);
        check("s3_host_first_rdwn", {31'd0, log_rdwn[3]}, 32'd1);
        i_host_request = 1'b0;
        wait_cyc(150);
        check("s3_reqs", req_cnt, 32'd5);
        check("s3_poll_after", {27'd0, log_reg[4]}, 32'd1);
        check("s3_done_cnt", done_cnt, 32'd1);

        // Scenario 4: host write of 0x1140 to reg 0
        i_host_request = 1'b1;
        i_host_rdwn    = 1'b0;
        i_host_reg     = 5'd0;
        i_host_wr_data = 16'h1140;
        wait_phy_req("s4_req_seen", 10);
        check("s4_rdwn", {31'd0, o_phy_rdwn}, 32'd0);
        check("s4_reg", {27'd0, o_phy_reg}, 32'd0);
        check("s4_wr", o_phy_wr_data, 32'h0000_1140);
        wait_host_done("s4_done_seen", 20);
        check("s4_rd_kept", {16'd0, o_host_rd_data}, 32'h1234);
        i_host_request = 1'b0;
        i_host_rdwn    = 1'b1;

        // Scenario 5: the poll at cycle 193 stalls for 200 cycles
        wait_cyc(170);
        phy_delay = 200;
        wait_cyc(194);
        check("s5_stall_req", req_cnt, 32'd7);
        phy_delay = 3;
        wait_cyc(300);
        check("s5_hold_reg", {27'd0, o_phy_reg}, 32'd1);
        check("s5_hold_rdwn", {31'd0, o_phy_rdwn}, 32'd1);
        check("s5_no_req", {31'd0, o_phy_request}, 32'd0);
        check("s5_reqs_mid", req_cnt, 32'd7);
        wait_cyc(420);
        check("s5_one_extra", req_cnt, 32'd8);
        check("s5_extra_reg", {27'd0, log_reg[7]}, 32'd1);

        // Scenario 6: reset while the host access waits on the PHY
        phy_regs[1] = 16'h796D;
        wait_cyc(470);
        check("s6_link_before", {31'd0, o_link_up}, 32'd1);
        check("s6_chg_before", chg_cnt, 32'd3);
        phy_delay      = 50;
        i_host_request = 1'b1;
        i_host_rdwn    = 1'b1;
        i_host_reg     = 5'd0;
        wait_phy_req("s6_req_seen", 10);
        repeat (3) @(negedge clk);
        i_rst          = 1'b1;
        i_host_request = 1'b0;
        @(negedge clk);
        check_all_zero("s6_rst");
        phy_delay = 3;
        i_rst     = 1'b0;
        @(negedge clk);
        check("s6_poll_req", {31'd0, o_phy_request}, 32'd1);
        check("s6_poll_reg", {27'd0, o_phy_reg}, 32'd1);
        repeat (20) @(negedge clk);
        check("s6_no_done", done_cnt, 32'd2);
        check("s6_link_after", {31'd0, o_link_up}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
